regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data bits per register.
REQ-002 SHALL have parameter DEPTH, default 6, number of registers (2..256).
REQ-003 SHALL derive localparam AW = max(1, clog2(DEPTH)), the address width.
REQ-004 SHALL use one clock, clock, and a synchronous active-high reset, reset; both ports are listed first.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high; starts the clear sequence.
REQ-007 Reg_EN  input  1  write enable.
REQ-008 WR  input  AW  write address.
REQ-009 WRD  input  WIDTH  write data.
REQ-010 RA  input  AW  read port A address.
REQ-011 RB  input  AW  read port B address.
REQ-012 A  output  WIDTH  registered read data, port A.
REQ-013 B  output  WIDTH  registered read data, port B.
REQ-014 busy  output  1  high while the clear sequence runs.
REQ-015 rd_err  output  1  registered; high when RA or RB sampled at the previous edge was >= DEPTH.
REQ-016 wr_err  output  1  registered one-cycle pulse for a rejected write.

Function
REQ-017 SHALL implement a two-state FSM: CLEAR, READY.
REQ-018 In CLEAR, SHALL write zero to reg[idx] each cycle and increment idx from 0; after idx = DEPTH-1 it SHALL go to READY on the next edge (CLEAR lasts exactly DEPTH cycles).
REQ-019 busy SHALL be 1 exactly when the state is CLEAR.
REQ-020 In READY, when Reg_EN=1 and WR<DEPTH, reg[WR] SHALL take WRD at the rising edge.
REQ-021 When Reg_EN=1 and WR>=DEPTH, no register SHALL change and wr_err SHALL be 1 for the following cycle.
REQ-022 When Reg_EN=1 during CLEAR, the write SHALL be dropped and wr_err SHALL pulse.
REQ-023 Read latency SHALL be one cycle: A and B SHALL be updated at the edge from reg[RA] and reg[RB].
REQ-024 Ports A and B SHALL be independent; RA=RB SHALL return the same value on both ports.
REQ-025 A read address >= DEPTH SHALL return 0 on that port and set rd_err.
REQ-026 During CLEAR, A and B SHALL be loaded with 0.
REQ-027 A write to a register and a read of the same register in the same cycle SHALL follow REQ-043/REQ-044.

Reset
REQ-028 While reset=1 at an edge, the FSM SHALL enter CLEAR with idx=0.
REQ-029 While reset=1 at an edge, A, B, rd_err and wr_err SHALL be set to 0.
REQ-030 busy SHALL read 1 from the first edge with reset=1.
REQ-031 Register contents SHALL NOT be cleared by reset directly; they are zeroed by the CLEAR sequence.
REQ-032 Reset asserted during CLEAR or READY SHALL restart the clear sequence from idx=0.
REQ-033 Reset SHALL take priority over writes and reads.

Configuration
REQ-043 With REGFILE_BYPASS_EN defined: in READY, a valid write with WR=RA (or WR=RB) SHALL load WRD into A (or B) at the same edge (write-first).
REQ-044 Without REGFILE_BYPASS_EN: the same case SHALL return the old register value (read-first).
REQ-045 The macro SHALL affect nothing else.

Structure
REQ-046 Package regfile_pkg SHALL hold the state typedef (CLEAR, READY) and the clog2-based address-width function.
REQ-047 The clear FSM and idx counter SHALL be in the sub-module regfile_clr_seq (outputs: busy, clr_we, clr_idx); the register array and read ports SHALL stay in regfile_param.

Verification
REQ-048 Reset for 1 cycle, DEPTH=6 -> busy=1 for exactly 6 cycles, then 0; reading all 6 registers -> 0.
REQ-049 Write WR=1, WRD=4'b0101, then read RA=1, RB=0 -> A=0101 and B=0000 one cycle later.
REQ-050 Same-cycle Reg_EN=1, WR=2, WRD=4'b1101, RA=2, with old reg2=0 -> A=1101 with REGFILE_BYPASS_EN, A=0000 without it.
REQ-051 Write WR=6 (out of range), then read RA=6 -> wr_err pulses once, no register changes, A=0, rd_err=1.
REQ-052 Write during busy, and reset asserted mid-READY -> write dropped with wr_err pulse; after reset, busy=1 for 6 cycles and all registers read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parameterised register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Address width for a given register count, never narrower than one bit.
  function automatic int addr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks idx 0..DEPTH-1 after reset, zeroing one register per cycle.
//   state | meaning
//   CLEAR | zeroing reg[clr_idx] this cycle, busy high
//   READY | normal operation, array owned by the write port
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      busy    <= 1'b1;
      clr_idx <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == LAST) begin
            state   <= READY;
            busy    <= 1'b0;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + AW'(1);
          end
        end
        READY: begin
          busy <= 1'b0;
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // busy mirrors the CLEAR state, so every busy cycle zeroes exactly one entry.
  assign clr_we = busy;

endmodule

// File: rtl/regfile_param.sv
// Two-read, one-write register file with self-clearing after reset.
// Define REGFILE_BYPASS_EN for write-first same-address reads; default is read-first.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 6,
  localparam int AW   = addr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Reg_EN,
  input  logic [AW-1:0]    WR,
  input  logic [WIDTH-1:0] WRD,
  input  logic [AW-1:0]    RA,
  input  logic [AW-1:0]    RB,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             rd_err,
  output logic             wr_err
);

  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic             clr_we;
  logic [AW-1:0]    clr_idx;
  logic             wr_ok;
  logic             ra_ok;
  logic             rb_ok;
  logic             wr_fire;

  regfile_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .clock   (clock),
    .reset   (reset),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  assign wr_ok   = ({1'b0, WR} < DEPTH_L);
  assign ra_ok   = ({1'b0, RA} < DEPTH_L);
  assign rb_ok   = ({1'b0, RB} < DEPTH_L);
  assign wr_fire = Reg_EN && wr_ok && !busy;

  // Storage has no reset of its own; the clear sequence zeroes it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (clr_we) begin
        mem[clr_idx] <= '0;
      end else if (wr_fire) begin
        mem[WR] <= WRD;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      A      <= '0;
      B      <= '0;
      rd_err <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      rd_err <= !ra_ok || !rb_ok;
      wr_err <= Reg_EN && (busy || !wr_ok);

      if (busy || !ra_ok) begin
        A <= '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_fire && (WR == RA)) begin
        A <= WRD;
`endif
      end else begin
        A <= mem[RA];
      end

      if (busy || !rb_ok) begin
        B <= '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_fire && (WR == RB)) begin
        B <= WRD;
`endif
      end else begin
        B <= mem[RB];
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param at WIDTH=4, DEPTH=6; honours REGFILE_BYPASS_EN.
module tb_regfile_param;

  localparam int W  = 4;
  localparam int D  = 6;
  localparam int AW = 3;

  logic          clock;
  logic          reset;
  logic          Reg_EN;
  logic [AW-1:0] WR;
  logic [W-1:0]  WRD;
  logic [AW-1:0] RA;
  logic [AW-1:0] RB;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          busy;
  logic          rd_err;
  logic          wr_err;

  int vectors;
  int miscompares;

  regfile_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clock  (clock),
    .reset  (reset),
    .Reg_EN (Reg_EN),
    .WR     (WR),
    .WRD    (WRD),
    .RA     (RA),
    .RB     (RB),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .rd_err (rd_err),
    .wr_err (wr_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; Reg_EN = 1'b0; WR = '0; WRD = '0; RA = '0; RB = '0;
    tick();
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b1 || A !== 4'h0 || B !== 4'h0 || rd_err !== 1'b0 || wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b A=%h B=%h rd_err=%b wr_err=%b, required 1 0 0 0 0",
               busy, A, B, rd_err, wr_err);
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    vectors++;
    if (n != 6 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy_len: busy cycles=%0d busy=%b, required 6 then 0", n, busy);
    end
    for (int i = 0; i < D; i++) begin
      RA = AW'(i); RB = AW'(D - 1 - i);
      tick();
      vectors++;
      if (A !== 4'h0 || B !== 4'h0 || rd_err !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_clear_read[%0d]: A=%h B=%h rd_err=%b, required 0 0 0", i, A, B, rd_err);
      end
    end
  endtask

  task automatic test_write_read();
    Reg_EN = 1'b1; WR = 3'd1; WRD = 4'b0101; RA = 3'd0; RB = 3'd0;
    tick();
    Reg_EN = 1'b0;
    vectors++;
    if (wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL write_no_err: wr_err=%b, required 0", wr_err);
    end
    RA = 3'd1; RB = 3'd0;
    tick();
    vectors++;
    if (A !== 4'b0101 || B !== 4'b0000) begin
      miscompares++;
      $display("FAIL write_read: A=%b B=%b, required 0101 0000", A, B);
    end
  endtask

  task automatic test_same_cycle();
    logic [W-1:0] exp;
`ifdef REGFILE_BYPASS_EN
    exp = 4'b1101;
`else
    exp = 4'b0000;
`endif
    Reg_EN = 1'b1; WR = 3'd2; WRD = 4'b1101; RA = 3'd2; RB = 3'd2;
    tick();
    Reg_EN = 1'b0;
    vectors++;
    if (A !== exp || B !== exp) begin
      miscompares++;
      $display("FAIL same_cycle_rw: A=%b B=%b, required %b on both", A, B, exp);
    end
    RB = 3'd1;
    tick();
    vectors++;
    if (A !== 4'b1101 || B !== 4'b0101) begin
      miscompares++;
      $display("FAIL same_cycle_after: A=%b B=%b, required 1101 0101", A, B);
    end
  endtask

  task automatic test_out_of_range();
    logic [W-1:0] exp;
    for (int i = 0; i < D; i++) begin
      Reg_EN = 1'b1; WR = AW'(i); WRD = W'(i + 9);
      tick();
    end
    Reg_EN = 1'b1; WR = 3'd6; WRD = 4'hF; RA = 3'd0; RB = 3'd0;
    tick();
    Reg_EN = 1'b0;
    vectors++;
    if (wr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL oob_wr_err_pulse: wr_err=%b, required 1", wr_err);
    end
    RA = 3'd6; RB = 3'd0;
    tick();
    vectors++;
    if (wr_err !== 1'b0 || A !== 4'h0 || B !== 4'h9 || rd_err !== 1'b1) begin
      miscompares++;
      $display("FAIL oob_read_a: wr_err=%b A=%h B=%h rd_err=%b, required 0 0 9 1", wr_err, A, B, rd_err);
    end
    RA = 3'd3; RB = 3'd7;
    tick();
    vectors++;
    if (A !== 4'hC || B !== 4'h0 || rd_err !== 1'b1) begin
      miscompares++;
      $display("FAIL oob_read_b: A=%h B=%h rd_err=%b, required c 0 1", A, B, rd_err);
    end
    for (int i = 0; i < D; i++) begin
      RA = AW'(i); RB = AW'(i);
      exp = W'(i + 9);
      tick();
      vectors++;
      if (A !== exp || B !== exp || rd_err !== 1'b0) begin
        miscompares++;
        $display("FAIL oob_no_change[%0d]: A=%h B=%h rd_err=%b, required %h %h 0", i, A, B, rd_err, exp, exp);
      end
    end
  endtask

  task automatic test_busy_write_and_reset();
    int n;
    reset = 1'b1; Reg_EN = 1'b1; WR = 3'd6; WRD = 4'hF; RA = 3'd7; RB = 3'd2;
    tick();
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b1 || wr_err !== 1'b0 || rd_err !== 1'b0 || A !== 4'h0 || B !== 4'h0) begin
      miscompares++;
      $display("FAIL midready_reset: busy=%b wr_err=%b rd_err=%b A=%h B=%h, required 1 0 0 0 0",
               busy, wr_err, rd_err, A, B);
    end
    WR = 3'd0; RA = 3'd1; RB = 3'd0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      tick();
      if (n == 1) begin
        Reg_EN = 1'b0;
        vectors++;
        if (wr_err !== 1'b1 || A !== 4'h0 || B !== 4'h0) begin
          miscompares++;
          $display("FAIL busy_write: wr_err=%b A=%h B=%h, required 1 0 0", wr_err, A, B);
        end
      end
    end
    vectors++;
    if (n != 6 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rereset_busy_len: busy cycles=%0d busy=%b, required 6 then 0", n, busy);
    end
    for (int i = 0; i < D; i++) begin
      RA = AW'(i); RB = AW'(i);
      tick();
      vectors++;
      if (A !== 4'h0 || B !== 4'h0 || wr_err !== 1'b0) begin
        miscompares++;
        $display("FAIL rereset_read[%0d]: A=%h B=%h wr_err=%b, required 0 0 0", i, A, B, wr_err);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0; Reg_EN = 1'b0; WR = '0; WRD = '0; RA = '0; RB = '0;
    tick();
    test_reset();
    test_write_read();
    test_same_cycle();
    test_out_of_range();
    test_busy_write_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
